// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, writes
// little-endian 32-bit words into instruction memory, verifies an 8-bit
// additive checksum, then releases the CPU from reset.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset; CPU held in reset, waiting for start
//   LEN_LO | waiting for word-count byte N[7:0]
//   LEN_HI | waiting for word-count byte N[15:8]; length checked here
//   DATA   | assembling 4 bytes per word, writing each completed word
//   CHECK  | waiting for the checksum byte
//   RUN    | load good; CPU out of reset
//   FAIL   | load rejected; error flag set, CPU held in reset
//
// ADDR_W must be at most 16 (the word index is a 16-bit counter) and wide
// enough to address MAX_WORDS-1.
module imem_loader #(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_RUN, S_FAIL
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t              r_state;
   state_t              w_next;
   logic [7:0]          r_len_lo;
   logic [15:0]         r_len;
   logic [15:0]         r_word_idx;
   logic [1:0]          r_byte_sel;
   logic [23:0]         r_asm;
   logic [7:0]          r_csum;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_done;
   logic                r_error;

   logic                w_ready;
   logic                w_accept;
   logic                w_start_ok;
   logic [15:0]         w_len;
   logic                w_len_bad;
   logic                w_word_end;
   logic                w_last_word;

   assign w_ready     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHECK);
   assign w_accept    = byte_valid & w_ready;
   assign w_start_ok  = start & ((r_state == S_IDLE) || (r_state == S_RUN) ||
                                 (r_state == S_FAIL));
   assign w_len       = {byte_data, r_len_lo};
   assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > MAX_N);
   assign w_word_end  = (r_byte_sel == 2'd3);
   assign w_last_word = (r_word_idx == (r_len - 16'd1));

   assign byte_ready = w_ready;
   assign busy       = w_ready;
   assign cpu_rst_n  = (r_state == S_RUN);
   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
   assign done       = r_done;
   assign error      = r_error;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_RUN, S_FAIL: if (start) w_next = S_LEN_LO;
         S_LEN_LO:              if (w_accept) w_next = S_LEN_HI;
         S_LEN_HI:              if (w_accept) w_next = w_len_bad ? S_FAIL : S_DATA;
         S_DATA:                if (w_accept && w_word_end && w_last_word) w_next = S_CHECK;
         S_CHECK:               if (w_accept) w_next = (byte_data == r_csum) ? S_RUN : S_FAIL;
         default:               w_next = S_IDLE;
      endcase
   end

   // Header capture, word assembly, checksum, write strobe and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_lo   <= '0;
         r_len      <= '0;
         r_word_idx <= '0;
         r_byte_sel <= '0;
         r_asm      <= '0;
         r_csum     <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         if (w_start_ok) begin
            r_error    <= 1'b0;
            r_word_idx <= '0;
            r_byte_sel <= '0;
            r_csum     <= '0;
         end
         if (w_accept) begin
            case (r_state)
               S_LEN_LO: r_len_lo <= byte_data;
               S_LEN_HI: begin
                  r_len <= w_len;
                  if (w_len_bad) r_error <= 1'b1;
               end
               S_DATA: begin
                  r_csum     <= r_csum + byte_data;
                  r_byte_sel <= r_byte_sel + 2'd1;
                  case (r_byte_sel)
                     2'd0: r_asm[7:0]   <= byte_data;
                     2'd1: r_asm[15:8]  <= byte_data;
                     2'd2: r_asm[23:16] <= byte_data;
                     default: begin
                        r_we       <= 1'b1;
                        r_addr     <= r_word_idx[ADDR_W-1:0];
                        r_wdata    <= {byte_data, r_asm};
                        r_word_idx <= r_word_idx + 16'd1;
                     end
                  endcase
               end
               S_CHECK: begin
                  if (byte_data == r_csum) r_done  <= 1'b1;
                  else                     r_error <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a reference model turns a word list into
// the byte stream and the expected memory writes; a monitor compares writes.
module tb_imem_loader;

   localparam int ADDR_W    = 12;
   localparam int MAX_WORDS = 4096;

   logic              clk = 1'b0;
   logic              rst, start, byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready, mem_we, cpu_rst_n, busy, done, error;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   wr_t         exp_wr[$];
   logic [31:0] words[$];
   logic [7:0]  stream[$];
   bit          exp_ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (mem_we === 1'b1) begin
         if (exp_wr.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.addr));
            check("wr_data", mem_wdata, w.data);
         end
      end
   end

   // Reference model: header, data bytes, checksum; expected writes queued.
   task automatic prepare(input logic [15:0] n_hdr, input bit corrupt);
      logic [7:0]  sum;
      logic [31:0] w;
      wr_t         e;
      stream.delete();
      stream.push_back(n_hdr[7:0]);
      stream.push_back(n_hdr[15:8]);
      if (n_hdr == 16'd0 || int'(n_hdr) > MAX_WORDS) begin
         exp_ok = 1'b0;
         return;
      end
      sum = 8'd0;
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         for (int b = 0; b < 4; b++) begin
            stream.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
         end
         e.addr = ADDR_W'(i);
         e.data = w;
         exp_wr.push_back(e);
      end
      stream.push_back(corrupt ? sum + 8'd1 : sum);
      exp_ok = !corrupt;
   endtask

   // Called at posedge+1; returns with inputs idle at posedge+1.
   task automatic send(input int gap_pct, input int start_at, input int nbytes, output int waits);
      int cyc;
      waits = 0;
      for (int k = 0; k < nbytes; k++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         byte_valid = 1'b1;
         byte_data  = stream[k];
         start      = (k == start_at);
         cyc = 0;
         @(negedge clk);
         while (byte_ready !== 1'b1 && cyc < 50) begin
            cyc++;
            waits++;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
         end
         if (cyc >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: byte %0d never accepted, expected acceptance", k);
            @(posedge clk); #1;
            byte_valid = 1'b0;
            start      = 1'b0;
            return;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      byte_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("start_err_clr", 32'(error), 32'd0);
   endtask

   task automatic run_load(input logic [15:0] n_hdr, input bit corrupt, input int gap_pct, input int start_at);
      int d0, waits, sa;
      d0 = done_cnt;
      do_start();
      prepare(n_hdr, corrupt);
      sa = (start_at == -2) ? int'($urandom_range(stream.size() - 1)) : start_at;
      send(gap_pct, sa, stream.size(), waits);
      repeat (3) @(posedge clk);
      #1;
      if (gap_pct == 0) check("bubbles", 32'(waits), 32'd0);
      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("done_pulses", 32'(done_cnt - d0), 32'(exp_ok));
      check("cpu_rst_n", 32'(cpu_rst_n), 32'(exp_ok));
      check("error", 32'(error), 32'(!exp_ok));
      check("busy_end", 32'(busy), 32'd0);
      check("ready_end", 32'(byte_ready), 32'd0);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits, n, d0;
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      byte_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("idle_ready", 32'(byte_ready), 32'd0);

      // Good load and bad checksum on the reference program.
      words.delete();
      words.push_back(32'h0000_0013);
      words.push_back(32'h0010_0093);
      run_load(16'd2, 1'b0, 0, -1);
      run_load(16'd2, 1'b1, 0, -1);

      // Illegal lengths.
      words.delete();
      run_load(16'd0, 1'b0, 0, -1);
      run_load(16'h1001, 1'b0, 0, -1);

      // Flow control: same 3 words, gap-free then with random gaps.
      rand_words(3);
      run_load(16'd3, 1'b0, 0, -1);
      run_load(16'd3, 1'b0, 50, -1);

      // Start pulse during DATA is ignored.
      rand_words(3);
      run_load(16'd3, 1'b0, 0, 7);

      // Reset after 6 data bytes: only word 0 gets written.
      rand_words(3);
      d0 = done_cnt;
      do_start();
      prepare(16'd3, 1'b0);
      while (exp_wr.size() > 1) void'(exp_wr.pop_back());
      send(0, -1, 8, waits);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("abort_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("abort_writes", 32'(exp_wr.size()), 32'd0);
      check("abort_done", 32'(done_cnt - d0), 32'd0);
      check("abort_cpu_rst_n_hold", 32'(cpu_rst_n), 32'd0);

      // Randomized loads.
      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, 6));
         rand_words(n);
         run_load(16'(n), 1'($urandom_range(1)), ($urandom_range(1) == 1) ? 30 : 0, -2);
      end

      // Largest legal program: addresses up to MAX_WORDS-1, no wrap.
      rand_words(MAX_WORDS);
      run_load(16'(MAX_WORDS), 1'b0, 0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
